// File: rtl/pc_fetch_unit.sv
// Program counter / next-PC stage for the single-cycle LEGv8 datapath.
// Holds the fetch PC, resolves branch redirects and tracks stall/halt state.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_taken,
  input  logic             uncond_br,
  input  logic             br_reg,
  input  logic [63:0]      cond_addr19_se,
  input  logic [63:0]      br_addr26_se,
  input  logic [63:0]      reg_target,
  output logic [63:0]      pc,
  output logic [63:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             misaligned,
  output logic [CNT_W-1:0] taken_count,
  output logic             halted
);

  localparam int unsigned ADDR_W = 64;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] cond_off;
  logic [ADDR_W-1:0] uncond_off;
  logic              redirect;
  logic              mis_set;

  // Word-scaled offsets; the top two offset bits fall off the end.
  assign cond_off   = ADDR_W'(cond_addr19_se << 2);
  assign uncond_off = ADDR_W'(br_addr26_se << 2);
  assign pc_plus4   = pc + ADDR_W'(4);

  // Next-state and next-PC selection; the PC only moves in RUN.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    redirect  = 1'b0;
    mis_set   = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        mis_set = br_reg && (reg_target[1:0] != 2'b00);
        if (halt) begin
          state_nxt = ST_HALTED;
        end else if (stall) begin
          state_nxt = ST_STALL;
        end else if (br_reg) begin
          pc_nxt   = {reg_target[63:2], 2'b00};
          redirect = 1'b1;
        end else if (uncond_br) begin
          pc_nxt   = pc + uncond_off;
          redirect = 1'b1;
        end else if (br_taken) begin
          pc_nxt   = pc + cond_off;
          redirect = 1'b1;
        end else begin
          pc_nxt = pc_plus4;
        end
      end
      ST_STALL: begin
        if (halt) begin
          state_nxt = ST_HALTED;
        end else if (!stall) begin
          state_nxt = ST_RUN;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_BOOT;
    endcase
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      misaligned  <= 1'b0;
      taken_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_valid <= (state_nxt == ST_RUN);
      halted      <= (state_nxt == ST_HALTED);
      if (mis_set) begin
        misaligned <= 1'b1;
      end
      // Saturating redirect counter.
      if (redirect && (taken_count != '1)) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (RESET_VECTOR = 0x100).
module tb_pc_fetch_unit;

  localparam logic [63:0] RV = 64'h100;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        halt;
  logic        br_taken;
  logic        uncond_br;
  logic        br_reg;
  logic [63:0] cond_addr19_se;
  logic [63:0] br_addr26_se;
  logic [63:0] reg_target;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fetch_valid;
  logic        misaligned;
  logic [31:0] taken_count;
  logic        halted;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit #(.RESET_VECTOR(RV), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .br_taken(br_taken), .uncond_br(uncond_br), .br_reg(br_reg),
    .cond_addr19_se(cond_addr19_se), .br_addr26_se(br_addr26_se),
    .reg_target(reg_target), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .misaligned(misaligned),
    .taken_count(taken_count), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_br();
    br_taken  = 1'b0;
    uncond_br = 1'b0;
    br_reg    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; halt = 1'b0;
    clr_br();
    cond_addr19_se = '0; br_addr26_se = '0; reg_target = '0;
    #3;
    check("rst_pc", pc, RV);
    check("rst_pc4", pc_plus4, 64'h104);
    check("rst_fv", 64'(fetch_valid), 0);
    check("rst_halted", 64'(halted), 0);
    check("rst_mis", 64'(misaligned), 0);
    check("rst_cnt", 64'(taken_count), 0);
    #9 reset = 1'b0;
    #1;
    check("boot_pc", pc, RV);
    check("boot_fv", 64'(fetch_valid), 0);

    // Free run: first valid fetch at the reset vector, then +4 per edge.
    step(); check("run0_pc", pc, RV); check("run0_fv", 64'(fetch_valid), 1);
    step(); check("run1_pc", pc, 64'h104);
    step(); check("run2_pc", pc, 64'h108); check("run2_cnt", 64'(taken_count), 0);

    br_reg = 1'b1; reg_target = 64'h200;
    step(); clr_br();
    check("br_pc", pc, 64'h200); check("br_cnt", 64'(taken_count), 1);
    check("br_mis", 64'(misaligned), 0);

    br_taken = 1'b1; cond_addr19_se = 64'hFFFF_FFFF_FFFF_FFFE;
    step(); clr_br();
    check("cond_neg_pc", pc, 64'h1F8); check("cond_neg_cnt", 64'(taken_count), 2);

    br_reg = 1'b1; reg_target = 64'h200;
    step(); clr_br();
    check("back_pc", pc, 64'h200);

    // All three at once: register branch wins and flags misalignment.
    br_reg = 1'b1; uncond_br = 1'b1; br_taken = 1'b1;
    reg_target = 64'h1003; br_addr26_se = 64'h40; cond_addr19_se = 64'h80;
    step(); clr_br();
    check("prio_pc", pc, 64'h1000); check("prio_mis", 64'(misaligned), 1);
    check("prio_cnt", 64'(taken_count), 4);

    uncond_br = 1'b1; br_taken = 1'b1; br_addr26_se = 64'h5; cond_addr19_se = 64'h100;
    step(); clr_br();
    check("unc_pc", pc, 64'h1014); check("unc_pc4", pc_plus4, 64'h1018);
    check("unc_cnt", 64'(taken_count), 5);

    br_reg = 1'b1; reg_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); clr_br();
    check("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC); check("top_pc4", pc_plus4, 64'h0);
    step();
    check("wrap_pc", pc, 64'h0); check("wrap_cnt", 64'(taken_count), 6);

    uncond_br = 1'b1; br_addr26_se = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); clr_br();
    check("unc_neg_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Offset bits shifted past bit 63 are discarded.
    br_taken = 1'b1; cond_addr19_se = 64'h4000_0000_0000_0001;
    step(); clr_br();
    check("shift_pc", pc, 64'h0); check("shift_cnt", 64'(taken_count), 8);

    // Stall with an unconditional branch held throughout.
    stall = 1'b1; uncond_br = 1'b1; br_addr26_se = 64'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 64'h0);
      check("stall_fv", 64'(fetch_valid), 0);
    end
    check("stall_cnt", 64'(taken_count), 8);
    stall = 1'b0;
    step();
    check("resume_pc", pc, 64'h0); check("resume_fv", 64'(fetch_valid), 1);
    step(); clr_br();
    check("resume_br_pc", pc, 64'h40); check("resume_cnt", 64'(taken_count), 9);

    // Halt is sticky and ignores branch requests.
    halt = 1'b1; br_reg = 1'b1; reg_target = 64'h800; uncond_br = 1'b1;
    step(); halt = 1'b0;
    check("halt_pc", pc, 64'h40); check("halt_h", 64'(halted), 1);
    check("halt_fv", 64'(fetch_valid), 0);
    for (int i = 0; i < 10; i++) begin
      br_taken = 1'b1; stall = i[0];
      step();
      check("halted_pc", pc, 64'h40);
      check("halted_h", 64'(halted), 1);
    end
    stall = 1'b0; clr_br();
    check("halted_cnt", 64'(taken_count), 9);
    check("halted_mis", 64'(misaligned), 1);

    // Asynchronous reset mid-cycle.
    #3 reset = 1'b1;
    #1;
    check("arst_pc", pc, RV); check("arst_h", 64'(halted), 0);
    check("arst_mis", 64'(misaligned), 0); check("arst_cnt", 64'(taken_count), 0);
    check("arst_fv", 64'(fetch_valid), 0);
    #1 reset = 1'b0;
    step();
    check("rerun_pc", pc, RV); check("rerun_fv", 64'(fetch_valid), 1);

    // A branch in flight is discarded by reset.
    br_reg = 1'b1; reg_target = 64'h900;
    #2 reset = 1'b1;
    step(); clr_br();
    check("flight_pc", pc, RV); check("flight_cnt", 64'(taken_count), 0);
    reset = 1'b0;
    step();
    check("flight_run_pc", pc, RV);
    step();
    check("flight_adv_pc", pc, 64'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program counter and next-PC stage of the single-cycle LEGv8 datapath. It consumes the 64-bit sign-extended branch offsets (CondAddr19 and BrAddr26, each widened by the immediate sign extender), word-scales them, and computes the next fetch address. It holds the architectural PC register and feeds instruction memory. It also produces the PC+4 link value for BL, a fetch-valid qualifier, a stall/halt state machine, and a taken-branch counter.

## Interface
Parameters:
- RESET_VECTOR, default 64'h0, PC value loaded on reset.
- CNT_W, default 32, width of the taken-branch counter.

Ports:
- clk  input  1  Single clock; all state updates on rising edge.
- reset  input  1  Asynchronous, active-high reset.
- stall  input  1  Hold the PC for this cycle.
- halt  input  1  Enter HALTED. Sticky until reset.
- br_taken  input  1  Conditional branch (B.cond/CBZ/CBNZ) resolved taken.
- uncond_br  input  1  B or BL this cycle.
- br_reg  input  1  BR this cycle. Target comes from reg_target.
- cond_addr19_se  input  64  Sign-extended CondAddr19 (word offset).
- br_addr26_se  input  64  Sign-extended BrAddr26 (word offset).
- reg_target  input  64  Register value for BR.
- pc  output  64  Current fetch address, registered.
- pc_plus4  output  64  pc + 4, combinational, used as the BL link value.
- fetch_valid  output  1  pc is a valid fetch this cycle.
- misaligned  output  1  Sticky. Set when a BR target has bits [1:0] != 0.
- taken_count  output  CNT_W  Number of redirects performed.
- halted  output  1  High in HALTED.

## Operation
- The FSM has four states: BOOT, RUN, STALL, HALTED.
- BOOT:
  - Entered on reset.
  - fetch_valid = 0 and pc = RESET_VECTOR.
  - Moves unconditionally to RUN on the next edge. The PC does not advance on that edge.
- RUN:
  - fetch_valid = 1.
  - On each edge the PC is loaded with next_pc.
  - Go to HALTED if halt, else to STALL if stall.
- STALL:
  - fetch_valid = 0 and the PC is held.
  - Return to RUN when stall = 0. halt has priority over stall.
- HALTED:
  - fetch_valid = 0, halted = 1, PC frozen.
  - Only reset exits this state.
- next_pc priority, evaluated in RUN only:
  1. halt or stall: pc (hold).
  2. br_reg: {reg_target[63:2], 2'b00}.
  3. uncond_br: pc + (br_addr26_se << 2).
  4. br_taken: pc + (cond_addr19_se << 2).
  5. Otherwise: pc + 4.
- Arithmetic:
  - All adds are 64-bit modulo 2^64. Wrap-around is silent.
  - Shift left by 2 discards the top two offset bits.
  - Negative offsets are handled by two's complement. No separate subtract path.
- misaligned:
  - Set on any RUN-state edge where br_reg = 1 and reg_target[1:0] != 0.
  - Cleared only by reset.
- taken_count:
  - Increments on each RUN-state edge where next_pc came from priority 2, 3 or 4.
  - Saturates at all-ones. No wrap.
- Any simultaneous branch inputs resolve by the priority above. Lower-priority requests that cycle are dropped, not queued.
- Branch inputs asserted during BOOT, STALL or HALTED are ignored.

## Timing
- Reset values, all applied asynchronously on reset assertion:
  - pc = RESET_VECTOR
  - state = BOOT
  - fetch_valid = 0
  - misaligned = 0
  - taken_count = 0
  - halted = 0
- Reset deasserted before edge 0:
  - Edge 0: BOOT → RUN.
  - After edge 0: first valid fetch, at RESET_VECTOR.
  - Edge 1: first PC change.
- Redirect latency is one edge. Branch inputs sampled at edge N give the target on pc after edge N.
- pc_plus4 tracks pc combinationally in the same cycle.
- Reset asserted mid-operation:
  - Immediate return to reset values, regardless of state or pending branch.
  - A branch in flight is discarded.
- Stall timing:
  - stall asserted in RUN: pc holds after that edge and fetch_valid drops.
  - stall deasserted in STALL: RUN on the next edge, and pc resumes advancing on the edge after that.

## Test plan
- Reset, then 4 free-running cycles with RESET_VECTOR = 0x100:
  - pc goes 0x100 (fetch_valid = 0), then 0x100 (valid), then 0x104, 0x108.
  - taken_count = 0.
- In RUN at pc = 0x200, conditional taken: br_taken = 1, cond_addr19_se = 64'hFFFF_FFFF_FFFF_FFFE (−2):
  - Next pc = 0x1F8.
  - taken_count increments by 1.
- In RUN at pc = 0x200, all three requests together: br_reg = 1, uncond_br = 1, br_taken = 1, reg_target = 0x1003:
  - Next pc = 0x1000.
  - misaligned = 1.
  - taken_count increments by 1.
- Wrap-around: pc = 64'hFFFF_FFFF_FFFF_FFFC, no branch:
  - Next pc = 0.
- Stall: stall for 3 cycles with uncond_br = 1 held throughout:
  - pc is frozen and fetch_valid = 0 for 3 cycles.
  - Branch taken only on the first RUN edge after the stall.
- Halt, then reset:
  - halt = 1: halted = 1 and pc is frozen for 10 cycles even with branches driven.
  - Reset asserted mid-cycle: pc = RESET_VECTOR and halted = 0 immediately, before the next edge.
